reflet_uart_bus_master: RTL and testbench

- Bus initiator driven over the serial line: a host sends commands on `rx`; the block issues single-word reads/writes on the system bus and replies on `tx`.
- Used for loading RAM and debug peek/poke with no CPU firmware.
- Drives the same `addr`/`write_en`/`data_out` bus the CPU drives; outputs are zero when idle so the system OR-combines them with the CPU's.
- The system asserts CPU hold while `bus_active` is high.

---
 rtl/reflet_uart_master_pkg.sv | 10 +
 rtl/reflet_uart_serdes.sv | 87 ++++++++
 rtl/reflet_uart_bus_master.sv | 140 ++++++++++++++
 tb/tb_reflet_uart_bus_master.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reflet_uart_master_pkg.sv
// reflet_uart_master_pkg: opcodes, reply codes and command FSM states shared by the UART bus master
package reflet_uart_master_pkg;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ = 8'h52;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  typedef enum logic [3:0] {
    IDLE, GET_AH, GET_AL, GET_DH, GET_DL, BUS_WR, BUS_RD0, BUS_RD1, SEND_H, SEND_L, SEND_1
  } state_t;
endpackage

// File: rtl/reflet_uart_serdes.sv
// reflet_uart_serdes: 8N1 receive/transmit bit engine, bit_clks clocks per bit
module reflet_uart_serdes #(
  parameter int bit_clks = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  input  logic [7:0] i_byte,
  input  logic       i_send,
  output logic       o_busy
);
  localparam int CW = $clog2(bit_clks);
  logic [2:0] r_rx_sync;
  logic r_rx_busy, r_byte_valid, r_frame_err;
  logic [CW-1:0] r_rx_cnt, r_tx_cnt;
  logic [3:0] r_rx_n, r_tx_n;
  logic [7:0] r_rx_sh;
  logic r_tx_busy, r_tx;
  logic [8:0] r_tx_sh;
  logic w_rx, w_fall;
  assign w_rx = r_rx_sync[1];
  assign w_fall = r_rx_sync[2] & ~r_rx_sync[1];
  assign o_byte = r_rx_sh;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err = r_frame_err;
  assign o_tx = r_tx;
  assign o_busy = r_tx_busy;
  // bit index 0 is the start bit, 1..8 data, 9 the stop bit
  always_ff @(posedge clk)
    if (!reset) begin
      r_rx_sync <= '1;
      r_rx_busy <= 1'b0;
      r_rx_cnt <= '0;
      r_rx_n <= '0;
      r_rx_sh <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[1:0], i_rx};
      r_byte_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (!r_rx_busy) begin
        if (w_fall) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt <= CW'(bit_clks / 2 - 1);
          r_rx_n <= '0;
        end
      end else if (r_rx_cnt != '0) r_rx_cnt <= r_rx_cnt - 1'b1;
      else begin
        r_rx_cnt <= CW'(bit_clks - 1);
        r_rx_n <= r_rx_n + 1'b1;
        if (r_rx_n == 4'd0) r_rx_busy <= ~w_rx;
        else if (r_rx_n == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_byte_valid <= w_rx;
          r_frame_err <= ~w_rx;
        end else r_rx_sh <= {w_rx, r_rx_sh[7:1]};
      end
    end
  always_ff @(posedge clk)
    if (!reset) begin
      r_tx <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_cnt <= '0;
      r_tx_n <= '0;
      r_tx_sh <= '1;
    end else if (!r_tx_busy) begin
      if (i_send) begin
        r_tx_busy <= 1'b1;
        r_tx <= 1'b0;
        r_tx_sh <= {1'b1, i_byte};
        r_tx_cnt <= CW'(bit_clks - 1);
        r_tx_n <= '0;
      end
    end else if (r_tx_cnt != '0) r_tx_cnt <= r_tx_cnt - 1'b1;
    else if (r_tx_n == 4'd9) r_tx_busy <= 1'b0;
    else begin
      r_tx <= r_tx_sh[0];
      r_tx_sh <= {1'b1, r_tx_sh[8:1]};
      r_tx_n <= r_tx_n + 1'b1;
      r_tx_cnt <= CW'(bit_clks - 1);
    end
endmodule

// File: rtl/reflet_uart_bus_master.sv
// reflet_uart_bus_master: serial-commanded single-word bus reader/writer with ACK/NAK/data replies.
// Define UART_MASTER_TIMEOUT_EN to abort a partial command with NAK after timeout_cycles idle clocks.
module reflet_uart_bus_master
  import reflet_uart_master_pkg::*;
#(
  parameter int clk_freq = 96000,
  parameter int baud_rate = 9600,
  parameter int timeout_cycles = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  input  logic [15:0] data_in,
  output logic [15:0] addr,
  output logic [15:0] data_out,
  output logic        write_en,
  output logic        bus_active
);
  localparam int bit_clks = clk_freq / baud_rate;
  if (bit_clks < 4 || timeout_cycles < 1) begin : g_bad_cfg
    $error("reflet_uart_bus_master: clk_freq/baud_rate must be >= 4 and timeout_cycles >= 1");
  end
  state_t r_state;
  logic r_wr, r_send, r_we, r_act;
  logic [15:0] r_abuf, r_rdata, r_addr, r_dout;
  logic [7:0] r_dh, r_reply, r_tx_byte;
  logic [7:0] w_byte;
  logic w_byte_valid, w_frame_err, w_busy, w_rx_ok, w_fire, w_get;
  reflet_uart_serdes #(.bit_clks(bit_clks)) u_serdes (
    .clk(clk), .reset(reset), .i_rx(rx), .o_tx(tx),
    .o_byte(w_byte), .o_byte_valid(w_byte_valid), .o_frame_err(w_frame_err),
    .i_byte(r_tx_byte), .i_send(r_send), .o_busy(w_busy)
  );
  assign w_rx_ok = w_byte_valid & ~w_frame_err;
  // r_send blocks a second launch in the cycle before the engine reports busy
  assign w_fire = ~w_busy & ~r_send;
  assign w_get = r_state inside {GET_AH, GET_AL, GET_DH, GET_DL};
  assign addr = r_addr;
  assign data_out = r_dout;
  assign write_en = r_we;
  assign bus_active = r_act;
`ifdef UART_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] r_to_cnt;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= IDLE;
      r_wr <= 1'b0;
      r_send <= 1'b0;
      r_we <= 1'b0;
      r_act <= 1'b0;
      r_abuf <= '0;
      r_rdata <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_dh <= '0;
      r_reply <= '0;
      r_tx_byte <= '0;
`ifdef UART_MASTER_TIMEOUT_EN
      r_to_cnt <= '0;
`endif
    end else begin
      r_send <= 1'b0;
      case (r_state)
        IDLE: if (w_rx_ok) begin
          r_wr <= w_byte == OP_WRITE;
          r_reply <= NAK;
          r_state <= (w_byte == OP_WRITE || w_byte == OP_READ) ? GET_AH : SEND_1;
        end
        GET_AH: if (w_rx_ok) begin
          r_abuf[15:8] <= w_byte;
          r_state <= GET_AL;
        end
        GET_AL: if (w_rx_ok) begin
          r_abuf[7:0] <= w_byte;
          if (r_wr) r_state <= GET_DH;
          else begin
            r_addr <= {r_abuf[15:8], w_byte};
            r_act <= 1'b1;
            r_state <= BUS_RD0;
          end
        end
        GET_DH: if (w_rx_ok) begin
          r_dh <= w_byte;
          r_state <= GET_DL;
        end
        GET_DL: if (w_rx_ok) begin
          r_addr <= r_abuf;
          r_dout <= {r_dh, w_byte};
          r_we <= 1'b1;
          r_act <= 1'b1;
          r_state <= BUS_WR;
        end
        BUS_WR: begin
          r_addr <= '0;
          r_dout <= '0;
          r_we <= 1'b0;
          r_act <= 1'b0;
          r_reply <= ACK;
          r_state <= SEND_1;
        end
        BUS_RD0: r_state <= BUS_RD1;
        BUS_RD1: begin
          r_rdata <= data_in;
          r_addr <= '0;
          r_act <= 1'b0;
          r_state <= SEND_H;
        end
        SEND_H: if (w_fire) begin
          r_send <= 1'b1;
          r_tx_byte <= r_rdata[15:8];
          r_state <= SEND_L;
        end
        SEND_L: if (w_fire) begin
          r_send <= 1'b1;
          r_tx_byte <= r_rdata[7:0];
          r_state <= IDLE;
        end
        SEND_1: if (w_fire) begin
          r_send <= 1'b1;
          r_tx_byte <= r_reply;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
`ifdef UART_MASTER_TIMEOUT_EN
      r_to_cnt <= (w_get && !w_rx_ok) ? r_to_cnt + 1'b1 : '0;
      if (w_get && !w_rx_ok && r_to_cnt == TW'(timeout_cycles - 1)) begin
        r_reply <= NAK;
        r_state <= SEND_1;
      end
`endif
    end
`ifndef UART_MASTER_TIMEOUT_EN
  logic w_unused;
  assign w_unused = w_get;
`endif
endmodule

// File: tb/tb_reflet_uart_bus_master.sv
// tb_reflet_uart_bus_master: scoreboard bench; stimulus queues expected bus cycles and reply bytes,
// independent monitors decode the bus and the tx line and compare against the queues.
module tb_reflet_uart_bus_master;
  localparam int BIT = 10;
  localparam int TO = 20000;
  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
  } bus_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic tx, write_en, bus_active;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] addr, data_out;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bus_t bus_q[$];
  logic [7:0] tx_q[$];
  bus_t bus_e;
  logic [7:0] tx_b, tx_e;
  logic tx_start, tx_stop;

  always #5 clk = ~clk;

  reflet_uart_bus_master #(.clk_freq(96000), .baud_rate(9600), .timeout_cycles(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .data_in(data_in),
    .addr(addr), .data_out(data_out), .write_en(write_en), .bus_active(bus_active)
  );

  // responder with one-cycle read latency: data appears the cycle after a read address is presented
  always @(posedge clk) data_in <= (bus_active === 1'b1 && write_en === 1'b0) ? 16'hABCD : 16'h0000;

  always @(negedge clk)
    if (mon_en) begin
      checks++;
      if (bus_active === 1'b1) begin
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: got we=%b addr=%h data=%h, required no bus cycle", write_en, addr, data_out);
        end else begin
          bus_e = bus_q.pop_front();
          if ({write_en, addr, data_out} !== bus_e) begin
            errors++;
            $display("FAIL bus_cycle: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                     write_en, addr, data_out, bus_e.we, bus_e.a, bus_e.d);
          end
        end
      end else if (bus_active !== 1'b0 || write_en !== 1'b0 || addr !== 16'h0 || data_out !== 16'h0) begin
        errors++;
        $display("FAIL bus_idle: got act=%b we=%b addr=%h data=%h, required all zero", bus_active, write_en, addr, data_out);
      end
    end

  initial forever begin
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin
      repeat (BIT / 2) @(negedge clk);
      tx_start = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        tx_b[i] = tx;
      end
      repeat (BIT) @(negedge clk);
      tx_stop = tx;
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got byte %h, required no reply", tx_b);
      end else begin
        tx_e = tx_q.pop_front();
        if (tx_b !== tx_e || tx_start !== 1'b0 || tx_stop !== 1'b1) begin
          errors++;
          $display("FAIL tx_byte: got %h start=%b stop=%b, required %h start=0 stop=1", tx_b, tx_start, tx_stop, tx_e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL reply_missing: %0d bytes outstanding, required 0", tx_q.size());
      tx_q.delete();
    end
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (bus_q.size() != 0) begin
      errors++;
      $display("FAIL bus_missing: %0d bus cycles outstanding, required 0", bus_q.size());
      bus_q.delete();
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (tx !== 1'b1 || addr !== 16'h0 || data_out !== 16'h0 || write_en !== 1'b0 || bus_active !== 1'b0) begin
      errors++;
      $display("FAIL %s: got tx=%b addr=%h data=%h we=%b act=%b, required tx=1 and zeros",
               name, tx, addr, data_out, write_en, bus_active);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    bus_q.push_back('{1'b1, a, d});
    tx_q.push_back(8'h06);
    send_byte(8'h57, 1'b1);
    send_byte(a[15:8], 1'b1);
    send_byte(a[7:0], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
    wait_done(400);
  endtask

  task automatic do_read(input logic [15:0] a);
    bus_q.push_back('{1'b0, a, 16'h0});
    bus_q.push_back('{1'b0, a, 16'h0});
    tx_q.push_back(8'hAB);
    tx_q.push_back(8'hCD);
    send_byte(8'h52, 1'b1);
    send_byte(a[15:8], 1'b1);
    send_byte(a[7:0], 1'b1);
    wait_done(600);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_reset("reset_state");
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    do_write(16'h8010, 16'h1234);
    do_read(16'h0005);
    tx_q.push_back(8'h15);
    send_byte(8'h41, 1'b1);
    wait_done(400);
    do_read(16'h0005);
    send_byte(8'h57, 1'b0);
    repeat (300) @(negedge clk);
    do_write(16'h1234, 16'h5678);
    send_byte(8'h57, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset("reset_mid_cmd_1");
    @(negedge clk);
    check_reset("reset_mid_cmd_2");
    reset = 1'b1;
    repeat (20) @(negedge clk);
    do_write(16'hAA55, 16'h0FF0);
`ifdef UART_MASTER_TIMEOUT_EN
    tx_q.push_back(8'h15);
`endif
    send_byte(8'h57, 1'b1);
    send_byte(8'h80, 1'b1);
    repeat (TO + 1) @(negedge clk);
    wait_done(400);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset_after_timeout");
    reset = 1'b1;
    repeat (20) @(negedge clk);
    do_read(16'h8010);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
